// File: rtl/scale_sweep_ctrl.sv
// Frequency-scale sequencer for the F2 function generator: button stepping with
// press-and-hold auto-repeat, plus a triangle sweep between SCALE_MIN and SCALE_MAX.
module scale_sweep_ctrl #(
    parameter int SCALE_W       = 6,
    parameter int SCALE_MIN     = 0,
    parameter int SCALE_MAX     = 63,
    parameter int SCALE_RST     = 32,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int SWEEP_CYCLES  = 25_000_000
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Plus,
    input  logic               Minus,
    input  logic               Sweep_En,
    output logic [SCALE_W-1:0] Scale,
    output logic               Scale_upd,
    output logic               Sweep_dir,
    output logic               Sweeping
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SWEEP_CYCLES) ? CNT_MAX_A : SWEEP_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SWEEP_LAST  = CNT_W'(SWEEP_CYCLES - 1);
    localparam logic [SCALE_W-1:0] S_MIN       = SCALE_W'(SCALE_MIN);
    localparam logic [SCALE_W-1:0] S_MAX       = SCALE_W'(SCALE_MAX);
    localparam logic [SCALE_W-1:0] S_RST       = SCALE_W'(SCALE_RST);
    localparam logic [SCALE_W-1:0] S_ONE       = SCALE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_REPEAT,
        ST_LOCK,
        ST_SWEEP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_plus_q;
    logic               r_minus_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SCALE_W-1:0] r_scale;
    logic [SCALE_W-1:0] w_scale_nxt;
    logic               r_upd;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_btn_plus;
    logic               w_btn_plus_nxt;

    logic               w_plus_rise;
    logic               w_minus_rise;
    logic               w_held;
    logic               w_both;
    logic               w_step;
    logic               w_step_up;
    logic               w_sweep_step;
    logic               w_at_min;
    logic               w_at_max;
    logic [SCALE_W-1:0] w_inc;
    logic [SCALE_W-1:0] w_dec;

    assign w_plus_rise  = Plus & ~r_plus_q;
    assign w_minus_rise = Minus & ~r_minus_q;
    assign w_both       = Plus & Minus;
    // r_btn_plus records which button owns the current PRESS/REPEAT hold
    assign w_held       = r_btn_plus ? Plus : Minus;

    assign w_at_min = (r_scale == S_MIN);
    assign w_at_max = (r_scale == S_MAX);
    assign w_inc    = w_at_max ? r_scale : r_scale + S_ONE;
    assign w_dec    = w_at_min ? r_scale : r_scale - S_ONE;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_plus_q   <= 1'b0;
            r_minus_q  <= 1'b0;
            r_cnt      <= '0;
            r_scale    <= S_RST;
            r_upd      <= 1'b0;
            r_dir      <= 1'b1;
            r_btn_plus <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_plus_q   <= Plus;
            r_minus_q  <= Minus;
            r_cnt      <= w_cnt_nxt;
            r_scale    <= w_scale_nxt;
            r_upd      <= (w_scale_nxt != r_scale);
            r_dir      <= w_dir_nxt;
            r_btn_plus <= w_btn_plus_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_btn_plus_nxt = r_btn_plus;
        w_step         = 1'b0;
        w_step_up      = 1'b0;
        w_sweep_step   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Sweep_En) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end else if (w_plus_rise && w_minus_rise) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_plus_rise || w_minus_rise) begin
                    w_step         = 1'b1;
                    w_step_up      = w_plus_rise;
                    w_btn_plus_nxt = w_plus_rise;
                    w_state_nxt    = ST_PRESS;
                    w_cnt_nxt      = '0;
                end
            end
            ST_PRESS: begin
                if (w_both) begin
                    w_state_nxt = ST_LOCK;
                end else if (!w_held) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == HOLD_LAST) begin
                    w_step      = 1'b1;
                    w_step_up   = r_btn_plus;
                    w_state_nxt = ST_REPEAT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (w_both) begin
                    w_state_nxt = ST_LOCK;
                end else if (!w_held) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_step    = 1'b1;
                    w_step_up = r_btn_plus;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (!Plus && !Minus) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (!Sweep_En) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SWEEP_LAST) begin
                    w_sweep_step = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_scale_nxt = r_scale;
        w_dir_nxt   = r_dir;

        if (w_step) begin
            w_scale_nxt = w_step_up ? w_inc : w_dec;
        end else if (w_sweep_step) begin
            // Sweep bounces off a bound in one step instead of dwelling there
            if (r_dir) begin
                if (w_at_max) begin
                    w_scale_nxt = S_MAX - S_ONE;
                    w_dir_nxt   = 1'b0;
                end else begin
                    w_scale_nxt = r_scale + S_ONE;
                end
            end else begin
                if (w_at_min) begin
                    w_scale_nxt = S_MIN + S_ONE;
                    w_dir_nxt   = 1'b1;
                end else begin
                    w_scale_nxt = r_scale - S_ONE;
                end
            end
        end

        if (w_scale_nxt == S_MIN) begin
            w_dir_nxt = 1'b1;
        end else if (w_scale_nxt == S_MAX) begin
            w_dir_nxt = 1'b0;
        end
    end

    assign Scale     = r_scale;
    assign Scale_upd = r_upd;
    assign Sweep_dir = r_dir;
    assign Sweeping  = (r_state == ST_SWEEP);

endmodule

// File: tb/tb_scale_sweep_ctrl.sv
// Scoreboard bench for scale_sweep_ctrl: a cycle-level behavioural model predicts
// the outputs after each clock edge; a negedge monitor compares them with the DUT.
module tb_scale_sweep_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int SWP  = 3;
    localparam int SMIN = 0;
    localparam int SMAX = 5;
    localparam int SRST = 2;

    logic       sysclk;
    logic       reset;
    logic       Plus;
    logic       Minus;
    logic       Sweep_En;
    logic [5:0] Scale;
    logic       Scale_upd;
    logic       Sweep_dir;
    logic       Sweeping;

    scale_sweep_ctrl #(
        .SCALE_W      (6),
        .SCALE_MIN    (SMIN),
        .SCALE_MAX    (SMAX),
        .SCALE_RST    (SRST),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .SWEEP_CYCLES (SWP)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .Plus     (Plus),
        .Minus    (Minus),
        .Sweep_En (Sweep_En),
        .Scale    (Scale),
        .Scale_upd(Scale_upd),
        .Sweep_dir(Sweep_dir),
        .Sweeping (Sweeping)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        int scale;
        int upd;
        int dir;
        int sw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: activity described by how long a button or sweep has lasted
    typedef enum int { M_IDLE, M_HELD, M_LOCK, M_SWEEP } mode_t;
    mode_t m_mode;
    int    m_scale;
    int    m_dir;
    int    m_upd;
    int    held_len;
    int    sweep_len;
    bit    owner_plus;
    bit    prev_p;
    bit    prev_m;

    function automatic void model_reset();
        m_mode    = M_IDLE;
        m_scale   = SRST;
        m_dir     = 1;
        m_upd     = 0;
        held_len  = 0;
        sweep_len = 0;
        owner_plus = 0;
        prev_p    = 0;
        prev_m    = 0;
    endfunction

    function automatic void nudge(input bit up);
        int n;
        n = up ? m_scale + 1 : m_scale - 1;
        if (n > SMAX) n = SMAX;
        if (n < SMIN) n = SMIN;
        m_scale = n;
    endfunction

    function automatic void sweep_move();
        m_scale = m_scale + (m_dir != 0 ? 1 : -1);
        if (m_scale > SMAX) begin
            m_scale = SMAX - 1;
            m_dir   = 0;
        end else if (m_scale < SMIN) begin
            m_scale = SMIN + 1;
            m_dir   = 1;
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.scale = m_scale;
        e.upd   = m_upd;
        e.dir   = m_dir;
        e.sw    = (m_mode == M_SWEEP) ? 1 : 0;
        q.push_back(e);
    endfunction

    function automatic void model_edge();
        bit rp;
        bit rm;
        int old;
        if (!reset) begin
            model_reset();
        end else begin
            old = m_scale;
            rp  = Plus && !prev_p;
            rm  = Minus && !prev_m;
            case (m_mode)
                M_IDLE: begin
                    if (Sweep_En) begin
                        m_mode    = M_SWEEP;
                        sweep_len = 0;
                    end else if (rp && rm) begin
                        m_mode = M_LOCK;
                    end else if (rp || rm) begin
                        nudge(rp);
                        owner_plus = rp;
                        m_mode     = M_HELD;
                        held_len   = 0;
                    end
                end
                M_HELD: begin
                    if (Plus && Minus) begin
                        m_mode = M_LOCK;
                    end else if (!(owner_plus ? Plus : Minus)) begin
                        m_mode = M_IDLE;
                    end else begin
                        held_len++;
                        if (held_len == HOLD || (held_len > HOLD && (held_len - HOLD) % REP == 0))
                            nudge(owner_plus);
                    end
                end
                M_LOCK: begin
                    if (!Plus && !Minus) m_mode = M_IDLE;
                end
                M_SWEEP: begin
                    if (!Sweep_En) begin
                        m_mode = M_IDLE;
                    end else begin
                        sweep_len++;
                        if (sweep_len % SWP == 0) sweep_move();
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_scale == SMIN) m_dir = 1;
            else if (m_scale == SMAX) m_dir = 0;
            m_upd  = (m_scale != old) ? 1 : 0;
            prev_p = Plus;
            prev_m = Minus;
        end
        push_expect();
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge sysclk) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty: got no expectation at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("Scale", int'(Scale), e.scale);
            chk("Scale_upd", int'(Scale_upd), e.upd);
            chk("Sweep_dir", int'(Sweep_dir), e.dir);
            chk("Sweeping", int'(Sweeping), e.sw);
        end
    end

    task automatic run(input logic p, input logic m, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            Plus     = p;
            Minus    = m;
            Sweep_En = s;
            @(posedge sysclk);
            model_edge();
            #1;
        end
    endtask

    // Reset is pulled low mid-cycle, so the reset values must appear before the next edge
    task automatic do_reset(input int n);
        #1;
        reset    = 1'b0;
        Plus     = 1'b0;
        Minus    = 1'b0;
        Sweep_En = 1'b0;
        q.delete();
        model_reset();
        push_expect();
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            model_edge();
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        Plus     = 1'b0;
        Minus    = 1'b0;
        Sweep_En = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge sysclk);
            model_edge();
            #1;
        end
        reset = 1'b1;

        run(0, 0, 0, 2);
        run(1, 0, 0, 1);
        run(0, 0, 0, 4);
        run(1, 0, 0, 30);
        run(0, 0, 0, 3);
        run(1, 1, 0, 3);
        run(0, 0, 0, 2);
        run(0, 1, 0, 1);
        run(0, 0, 0, 3);
        run(0, 1, 0, 5);
        run(1, 1, 0, 12);
        run(0, 1, 0, 4);
        run(0, 0, 0, 3);

        do_reset(2);
        run(0, 0, 1, 30);
        run(0, 0, 0, 6);
        run(1, 0, 1, 4);
        run(1, 0, 0, 4);
        run(0, 0, 0, 2);

        run(0, 1, 0, 15);
        do_reset(2);
        run(0, 0, 0, 2);
        run(0, 0, 1, 7);
        do_reset(2);
        run(0, 0, 0, 3);

        for (int k = 0; k < 90; k++) begin
            logic p;
            logic m;
            logic s;
            p = 1'($urandom_range(0, 1));
            m = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) == 0);
            run(p, m, s, $urandom_range(1, 14));
            if ($urandom_range(0, 2) == 0) run(0, 0, 0, $urandom_range(1, 3));
        end
        run(0, 0, 0, 2);

        @(negedge sysclk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
